// File: rtl/bitrf_flush_walker_pkg.sv
// Shared constants and types for the dirty-bit flush walker.
// The optional clear-after-accept behaviour is selected in the top by BITRF_WALK_CLEAR_EN.
package bitrf_flush_walker_pkg;

    localparam int SETS = 8192;
    localparam int AW   = 13;
    localparam int WAYS = 4;
    localparam int WW   = 2;
    localparam int CW   = AW + 3;

    localparam logic [AW-1:0] LAST_SET = AW'(SETS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } walk_state_t;

endpackage

// File: rtl/bitrf_flush_walker_if.sv
// Handshake and regfile bundle between the flush controller, the walker and the bit regfile.
// master is the walker side, slave is the controller/regfile side.
interface bitrf_flush_walker_if;
    import bitrf_flush_walker_pkg::*;

    logic            start;
    logic            busy;
    logic            done;
    logic [CW-1:0]   wb_count;
    logic [AW-1:0]   rf_ra;
    logic [WAYS-1:0] rf_rd;
    logic [AW-1:0]   rf_wa;
    logic [WAYS-1:0] rf_way_sel;
    logic            rf_wr;
    logic            rf_in;
    logic            wb_valid;
    logic            wb_ready;
    logic [AW-1:0]   wb_set;
    logic [WW-1:0]   wb_way;

    modport master (
        input  start, rf_rd, wb_ready,
        output busy, done, wb_count, rf_ra, rf_wa, rf_way_sel, rf_wr, rf_in,
               wb_valid, wb_set, wb_way
    );

    modport slave (
        output start, rf_rd, wb_ready,
        input  busy, done, wb_count, rf_ra, rf_wa, rf_way_sel, rf_wr, rf_in,
               wb_valid, wb_set, wb_way
    );

endinterface

// File: rtl/bitrf_flush_walker_lowest_way_enc.sv
// Picks the lowest set way of a way vector: index, one-hot mask and a non-empty flag.
module lowest_way_enc
    import bitrf_flush_walker_pkg::*;
(
    input  logic [WAYS-1:0] vec_i,
    output logic [WW-1:0]   idx_o,
    output logic [WAYS-1:0] onehot_o,
    output logic            any_o
);

    // Scan from the top way down so the lowest set way is the last (winning) assignment.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vec_i[w]) begin
                idx_o       = WW'(w);
                onehot_o    = '0;
                onehot_o[w] = 1'b1;
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/bitrf_flush_walker.sv
// Walks every set of the dirty-bit regfile and issues one writeback request per dirty way.
// Define BITRF_WALK_CLEAR_EN to clear each dirty bit in the regfile as its request is accepted;
// without it the walk only reports and never writes the regfile.
module bitrf_flush_walker
    import bitrf_flush_walker_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    bitrf_flush_walker_if.master bus
);

    walk_state_t     state_q, state_d;
    logic [AW-1:0]   setCnt_q, setCnt_d;
    logic [WAYS-1:0] vec_q, vec_d;
    logic [CW-1:0]   wbCount_q, wbCount_d;

    logic [WW-1:0]   lowWay;
    logic [WAYS-1:0] lowOnehot;
    logic            vecAny;
    logic            accept;
    logic [WAYS-1:0] vecRemain;
    logic            lastSet;

    lowest_way_enc u_enc (
        .vec_i    (vec_q),
        .idx_o    (lowWay),
        .onehot_o (lowOnehot),
        .any_o    (vecAny)
    );

    assign accept    = (state_q == ISSUE) && vecAny && bus.wb_ready;
    assign vecRemain = vec_q & ~lowOnehot;
    assign lastSet   = (setCnt_q == LAST_SET);

    // State and datapath registers; reset aborts a walk immediately with no done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            setCnt_q  <= '0;
            vec_q     <= '0;
            wbCount_q <= '0;
        end else begin
            state_q   <= state_d;
            setCnt_q  <= setCnt_d;
            vec_q     <= vec_d;
            wbCount_q <= wbCount_d;
        end
    end

    // Next-state: clean sets advance one per cycle, dirty sets drain one way per accept.
    always_comb begin
        state_d   = state_q;
        setCnt_d  = setCnt_q;
        vec_d     = vec_q;
        wbCount_d = wbCount_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    setCnt_d  = '0;
                    wbCount_d = '0;
                    vec_d     = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                vec_d = bus.rf_rd;
                if (bus.rf_rd != '0) begin
                    state_d = ISSUE;
                end else if (lastSet) begin
                    state_d = DONE;
                end else begin
                    setCnt_d = setCnt_q + AW'(1);
                end
            end
            ISSUE: begin
                if (accept) begin
                    vec_d     = vecRemain;
                    wbCount_d = wbCount_q + CW'(1);
                    if (vecRemain == '0) begin
                        if (lastSet) begin
                            state_d = DONE;
                        end else begin
                            setCnt_d = setCnt_q + AW'(1);
                            state_d  = SCAN;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; request fields come straight from registers so they hold until accepted.
    always_comb begin
        bus.busy     = (state_q == SCAN) || (state_q == ISSUE);
        bus.done     = (state_q == DONE);
        bus.wb_count = wbCount_q;
        bus.rf_ra    = setCnt_q;
        bus.rf_wa    = setCnt_q;
        bus.wb_valid = (state_q == ISSUE) && vecAny;
        bus.wb_set   = setCnt_q;
        bus.wb_way   = lowWay;
        bus.rf_in    = 1'b0;
`ifdef BITRF_WALK_CLEAR_EN
        bus.rf_wr      = accept;
        bus.rf_way_sel = accept ? lowOnehot : '0;
`else
        bus.rf_wr      = 1'b0;
        bus.rf_way_sel = '0;
`endif
    end

endmodule

// File: tb/tb_bitrf_flush_walker.sv
// Directed bench for bitrf_flush_walker with a behavioural 8192x4 bit regfile.
// Expectations follow BITRF_WALK_CLEAR_EN when it is defined for the build.
module tb_bitrf_flush_walker;
    import bitrf_flush_walker_pkg::*;

`ifdef BITRF_WALK_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    bitrf_flush_walker_if bus ();

    bitrf_flush_walker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WAYS-1:0] mem [0:SETS-1];
    logic            fillReq;
    logic [WAYS-1:0] fillVal;
    logic            pokeReq;
    logic [AW-1:0]   pokeAddr;
    logic [WAYS-1:0] pokeData;

    assign bus.rf_rd = mem[bus.rf_ra];

    // Regfile model: bulk fill / single poke from the bench, per-way clear writes from the DUT.
    always @(posedge clk) begin
        if (fillReq) begin
            for (int s = 0; s < SETS; s++) mem[s] <= fillVal;
        end else if (pokeReq) begin
            mem[pokeAddr] <= pokeData;
        end else if (bus.rf_wr) begin
            for (int w = 0; w < WAYS; w++) begin
                if (bus.rf_way_sel[w]) mem[bus.rf_wa][w] <= bus.rf_in;
            end
        end
    end

    logic [AW-1:0]   accSet [$];
    logic [WW-1:0]   accWay [$];
    logic            accWr  [$];
    logic [WAYS-1:0] accSel [$];
    int              accCyc [$];
    int              rfWrSeen;
    int              validSeen;

    task automatic fillAll(input logic [WAYS-1:0] v);
        @(negedge clk);
        fillVal = v;
        fillReq = 1'b1;
        @(negedge clk);
        fillReq = 1'b0;
    endtask

    task automatic pokeSet(input logic [AW-1:0] a, input logic [WAYS-1:0] d);
        @(negedge clk);
        pokeAddr = a;
        pokeData = d;
        pokeReq  = 1'b1;
        @(negedge clk);
        pokeReq  = 1'b0;
    endtask

    task automatic startWalk();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Logs accepted requests each cycle until done or the cycle budget runs out.
    task automatic waitDone(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        accSet.delete();
        accWay.delete();
        accWr.delete();
        accSel.delete();
        accCyc.delete();
        rfWrSeen  = 0;
        validSeen = 0;
        while (cycles <= budget) begin
            #1;
            if (bus.wb_valid) validSeen++;
            if (bus.rf_wr) rfWrSeen++;
            if (bus.wb_valid && bus.wb_ready) begin
                accSet.push_back(bus.wb_set);
                accWay.push_back(bus.wb_way);
                accWr.push_back(bus.rf_wr);
                accSel.push_back(bus.rf_way_sel);
                accCyc.push_back(cycles);
            end
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fillAll(4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
        vectors++; if (bus.rf_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_wr: got %b expected 0", bus.rf_wr); end
        vectors++; if (bus.wb_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_wb_count: got %0d expected 0", bus.wb_count); end
        vectors++; if (bus.rf_ra !== 13'd0 || bus.rf_wa !== 13'd0 || bus.wb_set !== 13'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got ra=%0d wa=%0d set=%0d expected 0", bus.rf_ra, bus.rf_wa, bus.wb_set); end
        vectors++; if (bus.wb_way !== 2'd0 || bus.rf_way_sel !== 4'b0000 || bus.rf_in !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_way: got way=%0d sel=%b in=%b expected 0", bus.wb_way, bus.rf_way_sel, bus.rf_in); end
    endtask

    task automatic test_all_clean();
        int cyc;
        bit ok;
        fillAll(4'b0000);
        bus.wb_ready = 1'b1;
        startWalk();
        waitDone(9000, cyc, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL clean_done_timeout: got no done expected done"); end
        vectors++; if (cyc !== 8192) begin miscompares++; $display("[TB] FAIL clean_latency: got done in cycle %0d expected 8193", cyc + 1); end
        vectors++; if (validSeen !== 0) begin miscompares++; $display("[TB] FAIL clean_no_wb: got %0d valid cycles expected 0", validSeen); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_busy_at_done: got %b expected 0", bus.busy); end
        vectors++; if (bus.wb_count !== 16'd0) begin miscompares++; $display("[TB] FAIL clean_count: got %0d expected 0", bus.wb_count); end
        @(negedge clk);
        #1;
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL clean_done_pulse: got done=%b a cycle later expected 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        fillAll(4'b0000);
        pokeSet(13'd5, 4'b1010);
        bus.wb_ready = 1'b1;
        startWalk();
        waitDone(9000, cyc, ok);
        vectors++; if (ok !== 1'b1 || accSet.size() !== 2) begin miscompares++; $display("[TB] FAIL b2b_accepts: got done=%b accepts=%0d expected 1/2", ok, accSet.size()); end
        if (accSet.size() == 2) begin
            vectors++; if (accSet[0] !== 13'd5 || accWay[0] !== 2'd1) begin miscompares++; $display("[TB] FAIL b2b_first: got (%0d,%0d) expected (5,1)", accSet[0], accWay[0]); end
            vectors++; if (accSet[1] !== 13'd5 || accWay[1] !== 2'd3) begin miscompares++; $display("[TB] FAIL b2b_second: got (%0d,%0d) expected (5,3)", accSet[1], accWay[1]); end
            vectors++; if (accCyc[1] !== accCyc[0] + 1) begin miscompares++; $display("[TB] FAIL b2b_adjacent: got cycles %0d,%0d expected consecutive", accCyc[0], accCyc[1]); end
            vectors++; if (accWr[0] !== CLEAR_EN || accSel[0] !== (CLEAR_EN ? 4'b0010 : 4'b0000)) begin miscompares++; $display("[TB] FAIL b2b_clear_write: got wr=%b sel=%b expected wr=%b", accWr[0], accSel[0], CLEAR_EN); end
        end
        vectors++; if (cyc !== 8194) begin miscompares++; $display("[TB] FAIL b2b_latency: got %0d expected 8194", cyc); end
        vectors++; if (bus.wb_count !== 16'd2) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 2", bus.wb_count); end
        vectors++; if (mem[5] !== (CLEAR_EN ? 4'b0000 : 4'b1010)) begin miscompares++; $display("[TB] FAIL b2b_regfile: got set5=%b", mem[5]); end
    endtask

    task automatic test_stall();
        int  cyc;
        bit  ok;
        bit  found;
        int  stallErr;
        int  orderErr;
        fillAll(4'b0000);
        pokeSet(13'd8191, 4'b1111);
        bus.wb_ready = 1'b0;
        startWalk();
        found = 1'b0;
        for (int i = 0; i < 9000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.wb_valid) found = 1'b1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid_timeout: got no wb_valid expected request at set 8191"); end
        stallErr = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wb_valid !== 1'b1 || bus.wb_set !== 13'd8191 || bus.wb_way !== 2'd0 || bus.rf_wr !== 1'b0) stallErr++;
            @(negedge clk);
            #1;
        end
        vectors++; if (stallErr !== 0) begin miscompares++; $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", stallErr); end
        bus.wb_ready = 1'b1;
        waitDone(40, cyc, ok);
        vectors++; if (ok !== 1'b1 || accSet.size() !== 4) begin miscompares++; $display("[TB] FAIL stall_accepts: got done=%b accepts=%0d expected 1/4", ok, accSet.size()); end
        orderErr = 0;
        for (int i = 0; i < accSet.size(); i++) begin
            if (accSet[i] !== 13'd8191 || accWay[i] !== WW'(i)) orderErr++;
        end
        vectors++; if (orderErr !== 0) begin miscompares++; $display("[TB] FAIL stall_order: got %0d bad requests expected ways 0..3 of set 8191", orderErr); end
        vectors++; if (bus.wb_count !== 16'd4) begin miscompares++; $display("[TB] FAIL stall_count: got %0d expected 4", bus.wb_count); end
        @(negedge clk);
        #1;
        vectors++; if (bus.wb_count !== 16'd4 || bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_count_hold: got count=%0d busy=%b expected 4/0", bus.wb_count, bus.busy); end
        vectors++; if (mem[8191] !== (CLEAR_EN ? 4'b0000 : 4'b1111)) begin miscompares++; $display("[TB] FAIL stall_regfile: got set8191=%b", mem[8191]); end
    endtask

    task automatic test_every_set();
        int cyc;
        bit ok;
        int orderErr;
        int memErr;
        fillAll(4'b0001);
        bus.wb_ready = 1'b1;
        startWalk();
        waitDone(17000, cyc, ok);
        vectors++; if (ok !== 1'b1 || accSet.size() !== 8192) begin miscompares++; $display("[TB] FAIL every_accepts: got done=%b accepts=%0d expected 1/8192", ok, accSet.size()); end
        orderErr = 0;
        for (int i = 0; i < accSet.size(); i++) begin
            if (accSet[i] !== AW'(i) || accWay[i] !== 2'd0) orderErr++;
        end
        vectors++; if (orderErr !== 0) begin miscompares++; $display("[TB] FAIL every_order: got %0d out-of-order requests expected 0", orderErr); end
        vectors++; if (cyc !== 16384) begin miscompares++; $display("[TB] FAIL every_latency: got %0d expected 16384", cyc); end
        vectors++; if (bus.wb_count !== 16'd8192) begin miscompares++; $display("[TB] FAIL every_count: got %0d expected 8192", bus.wb_count); end
        memErr = 0;
        for (int s = 0; s < SETS; s++) begin
            if (mem[s] !== (CLEAR_EN ? 4'b0000 : 4'b0001)) memErr++;
        end
        vectors++; if (memErr !== 0) begin miscompares++; $display("[TB] FAIL every_regfile: got %0d wrong sets expected 0", memErr); end
    endtask

    task automatic test_reset_mid_issue();
        bit found;
        int doneSeen;
        fillAll(4'b0000);
        pokeSet(13'd50, 4'b0011);
        pokeSet(13'd100, 4'b0110);
        pokeSet(13'd150, 4'b1000);
        bus.wb_ready = 1'b1;
        startWalk();
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.wb_valid && bus.wb_set == 13'd100) found = 1'b1;
        end
        bus.wb_ready = 1'b0;
        vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_reach: got no request at set 100 expected one"); end
        #1;
        reset = 1'b1;
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 || bus.rf_wr !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_ctrl: got busy=%b valid=%b wr=%b done=%b expected 0", bus.busy, bus.wb_valid, bus.rf_wr, bus.done); end
        vectors++; if (bus.wb_count !== 16'd0 || bus.wb_set !== 13'd0 || bus.rf_ra !== 13'd0 || bus.wb_way !== 2'd0) begin miscompares++; $display("[TB] FAIL midrst_data: got count=%0d set=%0d ra=%0d way=%0d expected 0", bus.wb_count, bus.wb_set, bus.rf_ra, bus.wb_way); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy) doneSeen++;
        end
        vectors++; if (doneSeen !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_done: got %0d active cycles after reset expected 0", doneSeen); end
        vectors++; if (mem[50] !== (CLEAR_EN ? 4'b0000 : 4'b0011)) begin miscompares++; $display("[TB] FAIL midrst_set50: got %b", mem[50]); end
        vectors++; if (mem[100] !== 4'b0110 || mem[150] !== 4'b1000) begin miscompares++; $display("[TB] FAIL midrst_untouched: got set100=%b set150=%b expected 0110/1000", mem[100], mem[150]); end
    endtask

    task automatic test_report_only();
        int cyc;
        bit ok;
        fillAll(4'b0000);
        pokeSet(13'd7, 4'b0100);
        bus.wb_ready = 1'b1;
        startWalk();
        waitDone(9000, cyc, ok);
        vectors++; if (ok !== 1'b1 || accSet.size() !== 1) begin miscompares++; $display("[TB] FAIL set7_accepts: got done=%b accepts=%0d expected 1/1", ok, accSet.size()); end
        if (accSet.size() == 1) begin
            vectors++; if (accSet[0] !== 13'd7 || accWay[0] !== 2'd2) begin miscompares++; $display("[TB] FAIL set7_request: got (%0d,%0d) expected (7,2)", accSet[0], accWay[0]); end
        end
        vectors++; if (rfWrSeen !== (CLEAR_EN ? 1 : 0)) begin miscompares++; $display("[TB] FAIL set7_rf_wr: got %0d write cycles expected %0d", rfWrSeen, CLEAR_EN ? 1 : 0); end
        vectors++; if (mem[7] !== (CLEAR_EN ? 4'b0000 : 4'b0100)) begin miscompares++; $display("[TB] FAIL set7_regfile: got %b", mem[7]); end
        vectors++; if (bus.wb_count !== 16'd1) begin miscompares++; $display("[TB] FAIL set7_count: got %0d expected 1", bus.wb_count); end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.wb_ready = 1'b0;
        fillReq      = 1'b0;
        fillVal      = '0;
        pokeReq      = 1'b0;
        pokeAddr     = '0;
        pokeData     = '0;
        test_reset();
        test_all_clean();
        test_back_to_back();
        test_stall();
        test_every_set();
        test_reset_mid_issue();
        test_report_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
